// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse tracker: FSM state codes,
// status-byte bit positions and wheel accumulator limits.
package ps2_mouse_pkg;

    typedef logic [2:0] state_t;

    localparam state_t WAIT_B1 = 3'd0;
    localparam state_t WAIT_B2 = 3'd1;
    localparam state_t WAIT_B3 = 3'd2;
    localparam state_t WAIT_B4 = 3'd3;
    localparam state_t APPLY   = 3'd4;

    // Bit positions inside the first (status) byte of a packet
    localparam int B1_L    = 0;
    localparam int B1_R    = 1;
    localparam int B1_M    = 2;
    localparam int B1_SYNC = 3;
    localparam int B1_SX   = 4;
    localparam int B1_SY   = 5;
    localparam int B1_XOVF = 6;
    localparam int B1_YOVF = 7;

    localparam logic [7:0] WHEEL_MAX = 8'h7F;
    localparam logic [7:0] WHEEL_MIN = 8'h80;

endpackage

// File: rtl/ps2_axis_accum.sv
// One cursor axis: applies a 9-bit signed mouse delta to a fixed-point
// position and clamps the result to [0, SIZE*2**FRAC_BITS - 1].
module ps2_axis_accum #(
    parameter int SIZE      = 640,
    parameter int CUR_W     = 10,
    parameter int FRAC_BITS = 2,
    parameter int SUBTRACT  = 0
) (
    input  logic [CUR_W+FRAC_BITS-1:0] pos,
    input  logic [8:0]                 delta,
    input  logic                       ovf,
    output logic [CUR_W+FRAC_BITS-1:0] pos_next
);

    localparam int PW = CUR_W + FRAC_BITS;
    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] POS_MAX = SW'(SIZE * (2 ** FRAC_BITS) - 1);

    logic signed [SW-1:0] pos_ext;
    logic signed [SW-1:0] delta_ext;
    logic signed [SW-1:0] sum;

    always_comb begin
        pos_ext   = $signed({2'b00, pos});
        // An overflowed axis reports garbage magnitude, so it contributes nothing
        delta_ext = ovf ? '0 : SW'($signed(delta));
        sum       = (SUBTRACT != 0) ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
        if (sum < 0) begin
            pos_next = '0;
        end else if (sum > POS_MAX) begin
            pos_next = POS_MAX[PW-1:0];
        end else begin
            pos_next = sum[PW-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet framer and cursor tracker: frames 3/4-byte packets,
// resynchronises on bad sync bits or inter-byte timeout, tracks X/Y/wheel.
module ps2_mouse_tracker
    import ps2_mouse_pkg::*;
#(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int CUR_W          = 10,
    parameter int FRAC_BITS      = 2,
    parameter int WHEEL_EN       = 0,
    parameter int INVERT_Y       = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_data_ready,
    output logic             leftButton,
    output logic             rightButton,
    output logic             middleButton,
    output logic [CUR_W-1:0] cursorX,
    output logic [CUR_W-1:0] cursorY,
    output logic [7:0]       wheel_count,
    output logic             packet_valid,
    output logic             sync_error
);

    localparam int PW = CUR_W + FRAC_BITS;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] X_RESET = PW'((SCREEN_W / 2) * (2 ** FRAC_BITS));
    localparam logic [PW-1:0] Y_RESET = PW'((SCREEN_H / 2) * (2 ** FRAC_BITS));

    state_t        state_reg;
    logic [TW-1:0] timeout_reg;
    logic [2:0]    btn_pend_reg;
    logic          sx_reg, sy_reg, xovf_reg, yovf_reg;
    logic [7:0]    b2_reg, b3_reg;
    logic [3:0]    b4_reg;
    logic [PW-1:0] pos_x_reg, pos_y_reg;
    logic [PW-1:0] pos_x_next, pos_y_next;
    logic [2:0]    buttons_reg;
    logic [7:0]    wheel_reg;
    logic [7:0]    wheel_next;
    logic signed [8:0] wheel_sum;
    logic          packet_valid_reg, sync_error_reg;

    ps2_axis_accum #(
        .SIZE(SCREEN_W), .CUR_W(CUR_W), .FRAC_BITS(FRAC_BITS), .SUBTRACT(0)
    ) u_axis_x (
        .pos(pos_x_reg), .delta({sx_reg, b2_reg}), .ovf(xovf_reg), .pos_next(pos_x_next)
    );

    ps2_axis_accum #(
        .SIZE(SCREEN_H), .CUR_W(CUR_W), .FRAC_BITS(FRAC_BITS), .SUBTRACT(INVERT_Y)
    ) u_axis_y (
        .pos(pos_y_reg), .delta({sy_reg, b3_reg}), .ovf(yovf_reg), .pos_next(pos_y_next)
    );

    // Saturation is detected from the 9-bit sum disagreeing in its top two bits
    always_comb begin
        wheel_sum  = $signed({wheel_reg[7], wheel_reg}) + $signed({{5{b4_reg[3]}}, b4_reg});
        wheel_next = wheel_reg;
        if (WHEEL_EN != 0) begin
            if (wheel_sum[8] != wheel_sum[7]) begin
                wheel_next = wheel_sum[8] ? WHEEL_MIN : WHEEL_MAX;
            end else begin
                wheel_next = wheel_sum[7:0];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg        <= WAIT_B1;
            timeout_reg      <= '0;
            btn_pend_reg     <= '0;
            sx_reg           <= 1'b0;
            sy_reg           <= 1'b0;
            xovf_reg         <= 1'b0;
            yovf_reg         <= 1'b0;
            b2_reg           <= '0;
            b3_reg           <= '0;
            b4_reg           <= '0;
            pos_x_reg        <= X_RESET;
            pos_y_reg        <= Y_RESET;
            buttons_reg      <= '0;
            wheel_reg        <= '0;
            packet_valid_reg <= 1'b0;
            sync_error_reg   <= 1'b0;
        end else begin
            packet_valid_reg <= 1'b0;
            sync_error_reg   <= 1'b0;
            case (state_reg)
                // APPLY commits the finished packet and, like WAIT_B1, accepts a new status byte
                WAIT_B1, APPLY: begin
                    if (state_reg == APPLY) begin
                        pos_x_reg        <= pos_x_next;
                        pos_y_reg        <= pos_y_next;
                        buttons_reg      <= btn_pend_reg;
                        wheel_reg        <= wheel_next;
                        packet_valid_reg <= 1'b1;
                    end
                    timeout_reg <= '0;
                    state_reg   <= WAIT_B1;
                    if (ps2_data_ready) begin
                        if (ps2_data[B1_SYNC]) begin
                            btn_pend_reg <= {ps2_data[B1_M], ps2_data[B1_R], ps2_data[B1_L]};
                            sx_reg       <= ps2_data[B1_SX];
                            sy_reg       <= ps2_data[B1_SY];
                            xovf_reg     <= ps2_data[B1_XOVF];
                            yovf_reg     <= ps2_data[B1_YOVF];
                            state_reg    <= WAIT_B2;
                        end else begin
                            sync_error_reg <= 1'b1;
                        end
                    end
                end
                WAIT_B2, WAIT_B3, WAIT_B4: begin
                    if (ps2_data_ready) begin
                        timeout_reg <= '0;
                        if (state_reg == WAIT_B2) begin
                            b2_reg    <= ps2_data;
                            state_reg <= WAIT_B3;
                        end else if (state_reg == WAIT_B3) begin
                            b3_reg    <= ps2_data;
                            state_reg <= (WHEEL_EN != 0) ? WAIT_B4 : APPLY;
                        end else begin
                            b4_reg    <= ps2_data[3:0];
                            state_reg <= APPLY;
                        end
                    end else if (timeout_reg == TIMEOUT_LIMIT) begin
                        timeout_reg    <= '0;
                        state_reg      <= WAIT_B1;
                        sync_error_reg <= 1'b1;
                    end else begin
                        timeout_reg <= timeout_reg + 1'b1;
                    end
                end
                default: state_reg <= WAIT_B1;
            endcase
        end
    end

    assign leftButton   = buttons_reg[0];
    assign rightButton  = buttons_reg[1];
    assign middleButton = buttons_reg[2];
    assign cursorX      = pos_x_reg[PW-1:FRAC_BITS];
    assign cursorY      = pos_y_reg[PW-1:FRAC_BITS];
    assign wheel_count  = wheel_reg;
    assign packet_valid = packet_valid_reg;
    assign sync_error   = sync_error_reg;

endmodule
